adder_seq_ctrl: RTL and testbench

//  Sequencer that performs a multi-precision add (NIBBLES x 4 bits) on one shared

---
 rtl/adder_seq_ctrl_if.sv | 27 ++
 rtl/adder_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Start/done request bus between a controller and the
// nibble-serial adder sequencer.
interface adder_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         clear;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, clear, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, clear, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-precision adder: one 4-bit ripple adder reused per
// nibble, LSB nibble first, carry registered between nibbles.
module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_seq_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nx;
  logic [W-1:0]  sum_q;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic          busy_q;
  logic          done_q;
  logic          cout_q;
  logic [3:0]    na;
  logic [3:0]    nb;
  logic [3:0]    ns;
  logic          nco;

  always_comb begin
    na = '0;
    nb = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        na = a_q[4*i +: 4];
        nb = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin : adder_ripple4_struc2
    logic cy;
    cy = carry_q;
    ns = '0;
    for (int j = 0; j < 4; j++) begin
      ns[j] = na[j] ^ nb[j] ^ cy;
      cy    = (na[j] & nb[j]) | (cy & (na[j] ^ nb[j]));
    end
    nco = cy;
  end

  // Final nibble is merged here so sum loads the complete word.
  always_comb begin
    work_nx = work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        work_nx[4*i +: 4] = ns;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work    <= '0;
      sum_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else if (bus.clear) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work    <= work_nx;
          carry_q <= nco;
          if (idx == LAST) begin
            sum_q  <= work_nx;
            cout_q <= nco;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: NIBBLES=4, 1 and 8 instances,
// cycle model of the start/done protocol plus directed literals.
module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st [3];
  logic        cl [3];
  logic        ci [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        bz [3];
  logic        dn [3];
  logic        co [3];
  logic [31:0] sm [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adder_seq_ctrl_if #(.NIBBLES(4)) i4 ();
  adder_seq_ctrl_if #(.NIBBLES(1)) i1 ();
  adder_seq_ctrl_if #(.NIBBLES(8)) i8 ();

  assign i4.start = st[0];
  assign i4.clear = cl[0];
  assign i4.a     = av[0][15:0];
  assign i4.b     = bv[0][15:0];
  assign i4.cin   = ci[0];
  assign bz[0]    = i4.busy;
  assign dn[0]    = i4.done;
  assign co[0]    = i4.cout;
  assign sm[0]    = {16'h0, i4.sum};

  assign i1.start = st[1];
  assign i1.clear = cl[1];
  assign i1.a     = av[1][3:0];
  assign i1.b     = bv[1][3:0];
  assign i1.cin   = ci[1];
  assign bz[1]    = i1.busy;
  assign dn[1]    = i1.done;
  assign co[1]    = i1.cout;
  assign sm[1]    = {28'h0, i1.sum};

  assign i8.start = st[2];
  assign i8.clear = cl[2];
  assign i8.a     = av[2];
  assign i8.b     = bv[2];
  assign i8.cin   = ci[2];
  assign bz[2]    = i8.busy;
  assign dn[2]    = i8.done;
  assign co[2]    = i8.cout;
  assign sm[2]    = i8.sum;

  adder_seq_ctrl #(.NIBBLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  adder_seq_ctrl #(.NIBBLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  adder_seq_ctrl #(.NIBBLES(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));

  function automatic int nib(int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
  endfunction

  function automatic logic [63:0] msk(int k);
    return (64'd1 << (4 * nib(k))) - 64'd1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol-level model: result = a+b+cin, visible N edges after accept.
  logic        mb [3];
  logic        md [3];
  logic        mc [3];
  logic [31:0] ms [3];
  logic [63:0] mres [3];
  int          left [3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mb[k]   <= 1'b0;
        md[k]   <= 1'b0;
        mc[k]   <= 1'b0;
        ms[k]   <= '0;
        left[k] <= 0;
      end else if (cl[k]) begin
        mb[k] <= 1'b0;
        md[k] <= 1'b0;
      end else if (mb[k]) begin
        if (left[k] == 1) begin
          mb[k] <= 1'b0;
          md[k] <= 1'b1;
          ms[k] <= mres[k][31:0] & msk(k)[31:0];
          mc[k] <= mres[k][4*nib(k)];
        end
        left[k] <= left[k] - 1;
      end else if (st[k]) begin
        mres[k] <= ({32'h0, av[k]} & msk(k))
                 + ({32'h0, bv[k]} & msk(k))
                 + 64'(ci[k]);
        left[k] <= nib(k);
        mb[k]   <= 1'b1;
        md[k]   <= 1'b0;
      end else begin
        md[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bz[k], dn[k], co[k], sm[k]} !== {mb[k], md[k], mc[k], ms[k]}) begin
        errors++;
        $display("FAIL cycle dut%0d t=%0t got b%b d%b c%b s%h want b%b d%b c%b s%h",
                 k, $time, bz[k], dn[k], co[k], sm[k],
                 mb[k], md[k], mc[k], ms[k]);
      end
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic run_add(input int k, input logic [31:0] x, input logic [31:0] y,
                         input logic c, output logic [31:0] s,
                         output logic cy, output int nbz);
    bit ok;
    ok  = 1'b0;
    nbz = 0;
    s   = '0;
    cy  = 1'b0;
    @(negedge clk);
    st[k] = 1'b1;
    av[k] = x;
    bv[k] = y;
    ci[k] = c;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      st[k] = 1'b0;
      av[k] = $urandom;
      bv[k] = $urandom;
      if (bz[k]) nbz++;
      if (dn[k]) begin
        ok = 1'b1;
        s  = sm[k];
        cy = co[k];
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d got no done want done", k);
    end
  endtask

  logic [31:0] s;
  logic        c;
  int          nb;
  int          t1;
  int          nd;
  bit          got;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      cl[k] = 1'b0;
      ci[k] = 1'b0;
      av[k] = '0;
      bv[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bz[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_sum", sm[0], 0);
    chk("rst_cout", co[0], 0);
    rst_n = 1'b1;

    run_add(0, 32'h1234, 32'h4321, 1'b0, s, c, nb);
    chk("t1_sum", s, 32'h5555);
    chk("t1_cout", c, 0);
    chk("t1_busy_cycles", nb, 4);

    run_add(0, 32'hFFFF, 32'h0001, 1'b0, s, c, nb);
    chk("t2a_sum", s, 32'h0000);
    chk("t2a_cout", c, 1);
    run_add(0, 32'hFFFF, 32'hFFFF, 1'b1, s, c, nb);
    chk("t2b_sum", s, 32'hFFFF);
    chk("t2b_cout", c, 1);

    @(negedge clk);
    st[0] = 1'b1;
    av[0] = 32'h1111;
    bv[0] = 32'h2222;
    ci[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dn[0]) got = 1'b1;
      else begin
        av[0] = $urandom;
        bv[0] = $urandom;
      end
    end
    chk("t3_done1", got, 1);
    chk("t3_sum1", sm[0], 32'h3333);
    t1 = cyc;
    av[0] = 32'h0F0F;
    bv[0] = 32'h0101;
    ci[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("t3_busy_b2b", bz[0], 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dn[0]) got = 1'b1;
    end
    chk("t3_done2", got, 1);
    chk("t3_gap", cyc - t1, 5);
    chk("t3_sum2", sm[0], 32'h1011);
    chk("t3_cout2", co[0], 0);

    @(negedge clk);
    st[0] = 1'b1;
    av[0] = 32'h2222;
    bv[0] = 32'h2222;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    cl[0] = 1'b1;
    @(negedge clk);
    cl[0] = 1'b0;
    chk("t4_busy", bz[0], 0);
    chk("t4_done", dn[0], 0);
    chk("t4_sum_held", sm[0], 32'h1011);
    chk("t4_cout_held", co[0], 0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (dn[0]) nd++;
    end
    chk("t4_no_done", nd, 0);
    @(negedge clk);
    st[0] = 1'b1;
    cl[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    cl[0] = 1'b0;
    chk("t4_clear_start_idle", bz[0], 0);

    @(negedge clk);
    st[0] = 1'b1;
    av[0] = 32'hFFFF;
    bv[0] = 32'h0001;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", bz[0], 0);
    chk("t5_done", dn[0], 0);
    chk("t5_sum", sm[0], 0);
    chk("t5_cout", co[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_add(0, 32'h0BC7, 32'h0845, 1'b1, s, c, nb);
    chk("t5_sum_after", s, 32'h140D);
    chk("t5_cout_after", c, 0);

    run_add(1, 32'hB, 32'hC, 1'b1, s, c, nb);
    chk("t6_sum", s, 32'h8);
    chk("t6_cout", c, 1);
    chk("t6_busy_cycles", nb, 1);
    run_add(2, 32'hFFFF_FFFF, 32'h1, 1'b0, s, c, nb);
    chk("t6_n8_sum", s, 32'h0);
    chk("t6_n8_cout", c, 1);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        run_add(k, $urandom, $urandom, 1'($urandom_range(0, 1)), s, c, nb);
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
